// File: rtl/adc_spi_resp.sv
// SPI slave front end for an ADC: receives 16-bit channel commands and returns the previous channel's conversion.
// Optional error counter is enabled by defining ADC_RESP_ERRCNT_EN.
module adc_spi_resp #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [2:0]  chan,
  input  logic [11:0] chan_data,
  output logic        cmd_vld,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned RESP_W     = 12;
  // Only bits [13:0] of the command matter; bits 15:14 are shifted out unused.
  localparam int unsigned RX_W       = FRAME_BITS - 2;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall_c, ss_rise_c, sclk_rise_c, sclk_fall_c;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nx;
  logic [RX_W-1:0]     rx, rx_nx;
  logic [FRAME_BITS-1:0] tx, tx_nx;
  logic [RESP_W-1:0]   resp_hold;
  logic [2:0]          chan_nx;
  logic                cmd_vld_nx, frame_err_nx;

  // Input synchronizers plus one edge-detect stage; SS_n/SCLK idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b1;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
    end
  end

  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign ss_fall_c   = ss_d & ~ss_s;
  assign ss_rise_c   = ~ss_d & ss_s;
  assign sclk_rise_c = ~sclk_d & sclk_s;
  assign sclk_fall_c = sclk_d & ~sclk_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      chan      <= '0;
      cmd_vld   <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      rx        <= rx_nx;
      tx        <= tx_nx;
      chan      <= chan_nx;
      cmd_vld   <= cmd_vld_nx;
      frame_err <= frame_err_nx;
      MISO      <= (state_nx == SHIFT) ? tx_nx[FRAME_BITS-1] : 1'b0;
    end
  end

  // Next-state and frame decode; SS_n edges take priority over SCLK edges.
  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    rx_nx        = rx;
    tx_nx        = tx;
    chan_nx      = chan;
    cmd_vld_nx   = 1'b0;
    frame_err_nx = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall_c) begin
          state_nx   = SHIFT;
          bit_cnt_nx = '0;
          rx_nx      = '0;
          tx_nx      = {4'h0, resp_hold};
        end
      end
      SHIFT: begin
        if (ss_rise_c) begin
          state_nx = IDLE;
          if (bit_cnt == CNT_W'(FRAME_BITS)) begin
            cmd_vld_nx = 1'b1;
            chan_nx    = rx[RX_W-1 -: 3];
          end else begin
            frame_err_nx = 1'b1;
          end
        end else begin
          if (sclk_rise_c && (bit_cnt != CNT_W'(FRAME_BITS))) begin
            rx_nx      = {rx[RX_W-2:0], mosi_s};
            bit_cnt_nx = bit_cnt + CNT_W'(1);
          end
          // Falls before the first rise leave bit 15 on MISO.
          if (sclk_fall_c && (bit_cnt != '0)) begin
            tx_nx = {tx[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Conversion result is captured the clock after cmd_vld, once chan has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_hold <= '0;
    end else if (cmd_vld) begin
      resp_hold <= chan_data;
    end
  end

`ifdef ADC_RESP_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (frame_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_adc_spi_resp.sv
// Directed bench for adc_spi_resp: an SPI mode-3 master with per-scenario tasks and inline checks.
module tb_adc_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [2:0]  chan;
  logic [11:0] chan_data;
  logic        cmd_vld, frame_err;
  logic [7:0]  err_cnt;

  logic [11:0] chan_tbl [8];
  int n_cmp  = 0;
  int n_fail = 0;
  int vld_total = 0;
  int err_total = 0;

  localparam int HALF = 5;  // clk cycles per SCLK phase

  adc_spi_resp #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .chan(chan), .chan_data(chan_data), .cmd_vld(cmd_vld),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign chan_data = chan_tbl[chan];

  always @(negedge clk) begin
    if (cmd_vld === 1'b1) vld_total++;
    if (frame_err === 1'b1) err_total++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks nbits bits with SS_n already low; bits past 16 are sent as 1.
  task automatic spi_bits(input logic [15:0] cmd, input int nbits, output logic [15:0] resp);
    resp = '0;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b1;
      wait_clks(HALF);
      if (i < 16) resp = {resp[14:0], MISO};
      SCLK = 1'b1;
      wait_clks(HALF);
    end
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] resp);
    SS_n = 1'b0;
    wait_clks(HALF);
    spi_bits(cmd, nbits, resp);
    wait_clks(HALF);
    SS_n = 1'b1;
    MOSI = 1'b0;
    wait_clks(10);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clks(4);
    n_cmp++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso got=%b exp=0", MISO); end
    n_cmp++; if (chan !== 3'd0) begin n_fail++; $display("FAIL reset_chan got=%0d exp=0", chan); end
    n_cmp++; if (cmd_vld !== 1'b0 || frame_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_pulses got vld=%b err=%b exp=0/0", cmd_vld, frame_err); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_errcnt got=%h exp=00", err_cnt); end
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_first_frame;
    logic [15:0] r;
    int v0;
    v0 = vld_total;
    spi_frame(16'h0000, 16, r);
    n_cmp++; if (vld_total - v0 !== 1) begin n_fail++; $display("FAIL first_vld got=%0d exp=1", vld_total - v0); end
    n_cmp++; if (chan !== 3'd0) begin n_fail++; $display("FAIL first_chan got=%0d exp=0", chan); end
    n_cmp++; if (r !== 16'h0000) begin n_fail++; $display("FAIL first_resp got=%h exp=0000", r); end
    spi_frame(16'h0000, 16, r);
    n_cmp++; if (r !== 16'h0ABC) begin n_fail++; $display("FAIL second_resp got=%h exp=0abc", r); end
  endtask

  task automatic test_pipeline;
    logic [15:0] r;
    chan_tbl[4] = 12'h111;
    chan_tbl[5] = 12'h555;
    spi_frame(16'h2000, 16, r);
    n_cmp++; if (r !== 16'h0ABC) begin n_fail++; $display("FAIL pipe0_resp got=%h exp=0abc", r); end
    n_cmp++; if (chan !== 3'd4) begin n_fail++; $display("FAIL pipe0_chan got=%0d exp=4", chan); end
    spi_frame(16'h2800, 16, r);
    n_cmp++; if (r !== 16'h0111) begin n_fail++; $display("FAIL pipe1_resp got=%h exp=0111", r); end
    n_cmp++; if (chan !== 3'd5) begin n_fail++; $display("FAIL pipe1_chan got=%0d exp=5", chan); end
    spi_frame(16'h0000, 16, r);
    n_cmp++; if (r !== 16'h0555) begin n_fail++; $display("FAIL pipe2_resp got=%h exp=0555", r); end
  endtask

  task automatic test_short_frame;
    logic [15:0] r;
    int v0, e0;
    v0 = vld_total; e0 = err_total;
    spi_frame(16'hFFFF, 10, r);
    n_cmp++; if (err_total - e0 !== 1) begin n_fail++; $display("FAIL short_err got=%0d exp=1", err_total - e0); end
    n_cmp++; if (vld_total - v0 !== 0) begin n_fail++; $display("FAIL short_vld got=%0d exp=0", vld_total - v0); end
    n_cmp++; if (chan !== 3'd0) begin n_fail++; $display("FAIL short_chan got=%0d exp=0", chan); end
`ifdef ADC_RESP_ERRCNT_EN
    n_cmp++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL short_errcnt got=%h exp=01", err_cnt); end
`else
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL short_errcnt got=%h exp=00", err_cnt); end
`endif
    // resp_hold must still hold chan 0's conversion
    spi_frame(16'h2800, 16, r);
    n_cmp++; if (r !== 16'h0ABC) begin n_fail++; $display("FAIL short_hold got=%h exp=0abc", r); end
  endtask

  task automatic test_long_frame;
    logic [15:0] r;
    int v0, e0;
    v0 = vld_total; e0 = err_total;
    spi_frame(16'h2000, 20, r);
    n_cmp++; if (vld_total - v0 !== 1) begin n_fail++; $display("FAIL long_vld got=%0d exp=1", vld_total - v0); end
    n_cmp++; if (err_total - e0 !== 0) begin n_fail++; $display("FAIL long_err got=%0d exp=0", err_total - e0); end
    n_cmp++; if (chan !== 3'd4) begin n_fail++; $display("FAIL long_chan got=%0d exp=4", chan); end
    n_cmp++; if (r !== 16'h0555) begin n_fail++; $display("FAIL long_resp got=%h exp=0555", r); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] r;
    int v0, e0;
    v0 = vld_total; e0 = err_total;
    SS_n = 1'b0;
    wait_clks(HALF);
    spi_bits(16'h2800, 8, r);
    n_cmp++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL mid_miso_pre got=%b exp=1", MISO); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL mid_miso_rst got=%b exp=0", MISO); end
    SS_n = 1'b1;
    MOSI = 1'b0;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(10);
    n_cmp++; if (vld_total - v0 !== 0 || err_total - e0 !== 0) begin n_fail++;
      $display("FAIL mid_pulses got vld=%0d err=%0d exp=0/0", vld_total - v0, err_total - e0); end
    n_cmp++; if (chan !== 3'd0) begin n_fail++; $display("FAIL mid_chan_rst got=%0d exp=0", chan); end
    v0 = vld_total;
    spi_frame(16'h2800, 16, r);
    n_cmp++; if (vld_total - v0 !== 1) begin n_fail++; $display("FAIL mid_after_vld got=%0d exp=1", vld_total - v0); end
    n_cmp++; if (chan !== 3'd5) begin n_fail++; $display("FAIL mid_after_chan got=%0d exp=5", chan); end
    n_cmp++; if (r !== 16'h0000) begin n_fail++; $display("FAIL mid_after_resp got=%h exp=0000", r); end
  endtask

  task automatic test_err_saturate;
    logic [15:0] r;
    int e0;
    e0 = err_total;
    for (int i = 0; i < 300; i++) spi_frame(16'h0000, 1, r);
    n_cmp++; if (err_total - e0 !== 300) begin n_fail++; $display("FAIL sat_pulses got=%0d exp=300", err_total - e0); end
`ifdef ADC_RESP_ERRCNT_EN
    n_cmp++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_errcnt got=%h exp=ff", err_cnt); end
`else
    n_cmp++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL sat_errcnt got=%h exp=00", err_cnt); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 8; i++) chan_tbl[i] = 12'hABC;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    wait_clks(2);
    test_reset;
    test_first_frame;
    test_pipeline;
    test_short_frame;
    test_long_frame;
    test_reset_mid_frame;
    test_err_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_spi_resp.md
ADC_SPI_RESP -- requirements
Module: adc_spi_resp

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronizing SS_n/SCLK/MOSI (legal 2 or 3).
REQ-002 SHALL have clk  input  1  system clock, at least 8x SCLK frequency.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have SS_n  input  1  SPI slave select from master, active-low.
REQ-005 SHALL have SCLK  input  1  SPI clock from master, idle high.
REQ-006 SHALL have MOSI  input  1  serial command from master, MSB first.
REQ-007 SHALL have MISO  output  1  serial response to master, MSB first.
REQ-008 SHALL have chan  output  3  channel of last valid command, cmd bits [13:11].
REQ-009 SHALL have chan_data  input  12  conversion value for chan, supplied by the environment.
REQ-010 SHALL have cmd_vld  output  1  one-clk pulse when a complete 16-bit frame is received.
REQ-011 SHALL have frame_err  output  1  one-clk pulse when a frame ends with bit count other than 16.
REQ-012 SHALL have err_cnt  output  8  count of frame_err pulses (see Configuration).

Function
REQ-013 SHALL synchronize SS_n, SCLK, MOSI through SYNC_STAGES flops (SS_n/SCLK preset to 1), plus one extra flop for edge detection.
REQ-014 SHALL implement FSM IDLE -> SHIFT on synchronized SS_n falling; SHIFT -> IDLE on synchronized SS_n rising.
REQ-015 SHALL, on SS_n fall, load 16-bit tx shift register with {4'h0, resp_hold} so MISO presents bit 15 before the first SCLK rise.
REQ-016 SHALL in SHIFT sample MOSI into rx shift register on each synchronized SCLK rise and increment a 5-bit bit counter saturating at 16.
REQ-017 SHALL in SHIFT left-shift tx register on each synchronized SCLK fall after the first rise; MISO = tx[15].
REQ-018 SHALL drive MISO = 0 in IDLE.
REQ-019 SHALL ignore SCLK edges while in IDLE; bits beyond 16 SHALL not alter rx register or bit counter.
REQ-020 SHALL, on SS_n rise with bit counter == 16, pulse cmd_vld, load chan <= rx[13:11], in the same clk.
REQ-021 SHALL capture chan_data into 12-bit resp_hold exactly one clk after cmd_vld (chan_data valid combinationally from chan).
REQ-022 SHALL thus return the conversion of frame N's channel during frame N+1 (one-frame pipeline); e.g. cmd 16'h2000 selects chan 4, 16'h2800 selects chan 5.
REQ-023 SHALL, on SS_n rise with bit counter != 16, pulse frame_err, leave chan and resp_hold unchanged, no cmd_vld.
REQ-024 SHALL treat SS_n fall and SCLK edge detected in the same clk as SS_n fall only.
REQ-025 SHALL ignore rx bits [15:14] and [10:0].

Reset
REQ-026 SHALL on rst_n low: FSM IDLE, bit counter 0, rx/tx 0, resp_hold 0, chan 0, MISO 0, cmd_vld 0, frame_err 0, err_cnt 0.
REQ-027 SHALL on reset asserted mid-frame abort the frame with no cmd_vld or frame_err, then wait for next SS_n fall after release.

Configuration
REQ-028 SHALL with macro ADC_RESP_ERRCNT_EN defined increment err_cnt on each frame_err, saturating at 8'hFF.
REQ-029 SHALL without ADC_RESP_ERRCNT_EN tie err_cnt to 8'h00 and omit the counter logic; frame_err remains.

Verification
REQ-030 SHALL test: after reset, frame cmd 16'h0000 with chan_data=12'hABC -> cmd_vld once, chan=0, MISO returns 16'h0000; next frame returns 16'h0ABC.
REQ-031 SHALL test: frames 16'h2000 then 16'h2800 with chan_data = {0x111 for chan 4, 0x555 for chan 5} -> second frame returns 16'h0111, third returns 16'h0555.
REQ-032 SHALL test: 10-bit frame -> frame_err pulse, no cmd_vld, chan unchanged, err_cnt=1 (macro on) or 0 (macro off).
REQ-033 SHALL test: 20 SCLK cycles in one frame -> cmd_vld, chan from first 16 bits, no frame_err.
REQ-034 SHALL test: rst_n asserted after 8 bits -> MISO 0, no pulses; following full frame 16'h2800 -> cmd_vld, chan=5.
REQ-035 SHALL test: 300 short frames with macro on -> err_cnt=8'hFF.
